// File: rtl/uart_seq_pkg.sv
// Shared types for the UART pin sequencer: wrapper direction codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_seq_pkg;

   localparam int DIR_W = 2;

   // Direction field of the wrapper control bus; encoding fixed by the pin wrapper.
   typedef enum logic [DIR_W-1:0] {
      DIR_IDLE  = 2'b00,
      DIR_TX    = 2'b01,
      DIR_RX    = 2'b10,
      DIR_CLEAR = 2'b11
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_GAP,
      ST_READ,
      ST_READ_WAIT,
      ST_CLEAR
   } seq_state_t;

   // Pin direction presented while the FSM sits in a given state.
   function automatic dir_t stateDir(input seq_state_t s);
      dir_t d;
      case (s)
         ST_WRITE: d = DIR_TX;
         ST_READ:  d = DIR_RX;
         ST_CLEAR: d = DIR_CLEAR;
         default:  d = DIR_IDLE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/uart_pin_sequencer_if.sv
// Host-side byte streams of the UART pin sequencer (host->UART and UART->host).
// Latency: wires only.
// Backpressure: valid/ready on both streams; a byte moves when valid && ready.
//   tx_valid/tx_ready/tx_byte : host offers a byte to transmit
//   rx_valid/rx_ready/rx_byte : sequencer offers a received byte to the host
interface uart_pin_sequencer_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_byte;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_byte;

   modport master (
      output tx_valid, tx_byte, rx_ready,
      input  tx_ready, rx_valid, rx_byte
   );

   modport slave (
      input  tx_valid, tx_byte, rx_ready,
      output tx_ready, rx_valid, rx_byte
   );
endinterface

// File: rtl/uart_poll_timer.sv
// Reloadable 16-bit down-counter pacing RX polls; saturates at zero.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none.
//   clk, nReset : clock, async active-low reset (reset loads ReloadValue)
//   load        : reload ReloadValue on the next edge
//   zero        : count has reached 0
module uart_poll_timer #(
   parameter logic [15:0] ReloadValue = 16'd63
) (
   input  logic clk,
   input  logic nReset,
   input  logic load,
   output logic zero
);

   logic [15:0] count;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         count <= ReloadValue;
      end else if (load) begin
         count <= ReloadValue;
      end else if (count != 16'd0) begin
         count <= count - 16'd1;
      end
   end

   assign zero = (count == 16'd0);

endmodule

// File: rtl/uart_pin_sequencer.sv
// Drives the UART pin wrapper's control/tx_data pins from host byte streams, polls RX, issues clears.
// Latency: TX byte on pins 1 cycle after handshake, 3 cycles min per byte; RX byte valid 2 cycles after READ.
// Backpressure: tx_ready only in IDLE with no clear pending; single-entry RX holding register stalls polling until drained.
//   clk, nReset             : clock, async active-low reset
//   rate_sel                : baud select, copied to control[1:0] while idle
//   clear_req, rx_poll_en   : clear request pulse, periodic poll enable
//   host (slave modport)    : tx/rx byte streams to/from the host
//   control, tx_data        : wrapper pins ([3:2] direction, [1:0] rate; data-in)
//   rx_data, rts, err       : wrapper registered data-out, RX FIFO full, sticky error
//   err_seen, drop_cnt      : latched error, saturating count of dropped zero TX bytes
module uart_pin_sequencer
   import uart_seq_pkg::*;
#(
   parameter logic [15:0] PollInterval = 16'd64,
   parameter int unsigned ClearCycles  = 2
) (
   input  logic                  clk,
   input  logic                  nReset,
   input  logic [1:0]            rate_sel,
   input  logic                  clear_req,
   input  logic                  rx_poll_en,
   uart_pin_sequencer_if.slave   host,
   output logic [3:0]            control,
   output logic [7:0]            tx_data,
   input  logic [7:0]            rx_data,
   input  logic                  rts,
   input  logic                  err,
   output logic                  err_seen,
   output logic [7:0]            drop_cnt
);

   localparam logic [15:0] ClrReload  = 16'(ClearCycles - 1);
   localparam logic [15:0] PollReload = PollInterval - 16'd1;

   seq_state_t  state, stateNext;
   dir_t        dirQ;
   logic [1:0]  rateQ;
   logic [7:0]  txDataQ;
   logic        clearPending;
   logic [15:0] clrCnt;
   logic        rxValidQ;
   logic [7:0]  rxByteQ;
   logic        errSeenQ;
   logic [7:0]  dropCntQ;

   logic txReady, txHs, pollZero, pollGo;
   logic enterClear, enterRead;

   assign txReady = (state == ST_IDLE) && !clearPending;
   assign txHs    = host.tx_valid && txReady;
   // rts means the wrapper FIFO is full, so it overrides the poll interval.
   assign pollGo  = rx_poll_en && !rxValidQ && (pollZero || rts);

   // A clear request in the same cycle as a TX handshake still wins: the
   // accepted byte would be flushed by the clear anyway, so it is not sent.
   always_comb begin
      stateNext  = state;
      enterClear = 1'b0;
      enterRead  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clearPending || clear_req) begin
               stateNext  = ST_CLEAR;
               enterClear = 1'b1;
            end else if (txHs) begin
               if (host.tx_byte != 8'd0) stateNext = ST_WRITE;
            end else if (pollGo) begin
               stateNext = ST_READ;
               enterRead = 1'b1;
            end
         end
         ST_WRITE:     stateNext = ST_GAP;
         ST_GAP:       stateNext = ST_IDLE;
         ST_READ:      stateNext = ST_READ_WAIT;
         ST_READ_WAIT: stateNext = ST_IDLE;
         ST_CLEAR:     if (clrCnt == 16'd0) stateNext = ST_IDLE;
         default:      stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   uart_poll_timer #(.ReloadValue(PollReload)) pollTimer (
      .clk    (clk),
      .nReset (nReset),
      .load   (enterRead),
      .zero   (pollZero)
   );

   // Pin registers are loaded from the next state so the pins line up with the state.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         dirQ    <= DIR_IDLE;
         rateQ   <= 2'b00;
         txDataQ <= 8'd0;
      end else begin
         dirQ    <= stateDir(stateNext);
         txDataQ <= (stateNext == ST_WRITE) ? host.tx_byte : 8'd0;
         if (state == ST_IDLE) rateQ <= rate_sel;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         clearPending <= 1'b0;
         clrCnt       <= 16'd0;
         errSeenQ     <= 1'b0;
         dropCntQ     <= 8'd0;
      end else begin
         if (enterClear)     clearPending <= 1'b0;
         else if (clear_req) clearPending <= 1'b1;

         if (enterClear)                                  clrCnt <= ClrReload;
         else if (state == ST_CLEAR && clrCnt != 16'd0)   clrCnt <= clrCnt - 16'd1;

         if (enterClear) errSeenQ <= 1'b0;
         else if (err)   errSeenQ <= 1'b1;

         if (txHs && host.tx_byte == 8'd0 && dropCntQ != 8'hFF) dropCntQ <= dropCntQ + 8'd1;
      end
   end

   // Single-entry RX holding register. A zero sample is an empty poll.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         rxValidQ <= 1'b0;
         rxByteQ  <= 8'd0;
      end else if (enterClear) begin
         rxValidQ <= 1'b0;
      end else if (state == ST_READ_WAIT && rx_data != 8'd0) begin
         rxValidQ <= 1'b1;
         rxByteQ  <= rx_data;
      end else if (rxValidQ && host.rx_ready) begin
         rxValidQ <= 1'b0;
      end
   end

   assign control       = {dirQ, rateQ};
   assign tx_data       = txDataQ;
   assign host.tx_ready = txReady;
   assign host.rx_valid = rxValidQ;
   assign host.rx_byte  = rxByteQ;
   assign err_seen      = errSeenQ;
   assign drop_cnt      = dropCntQ;

endmodule

// File: tb/tb_uart_pin_sequencer.sv
// Self-checking bench for uart_pin_sequencer: directed vector table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: bench randomizes tx_valid and rx_ready.
module tb_uart_pin_sequencer;
   import uart_seq_pkg::*;

   localparam int PI  = 4;
   localparam int CLR = 2;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic [1:0] rate_sel;
   logic       clear_req, rx_poll_en, rts, err;
   logic [7:0] rx_data;
   logic [3:0] control;
   logic [7:0] tx_data;
   logic       err_seen;
   logic [7:0] drop_cnt;

   uart_pin_sequencer_if hostIf();

   uart_pin_sequencer #(.PollInterval(16'(PI)), .ClearCycles(CLR)) dut (
      .clk        (clk),
      .nReset     (nReset),
      .rate_sel   (rate_sel),
      .clear_req  (clear_req),
      .rx_poll_en (rx_poll_en),
      .host       (hostIf),
      .control    (control),
      .tx_data    (tx_data),
      .rx_data    (rx_data),
      .rts        (rts),
      .err        (err),
      .err_seen   (err_seen),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic idleInputs();
      hostIf.tx_valid = 1'b0; hostIf.tx_byte = 8'h00; hostIf.rx_ready = 1'b0;
      rate_sel = 2'b00; clear_req = 1'b0; rx_poll_en = 1'b0; rts = 1'b0; rx_data = 8'h00; err = 1'b0;
   endtask

   // Leaves the bench at a falling edge with reset just released.
   task automatic doReset();
      nReset = 1'b0;
      idleInputs();
      repeat (2) @(negedge clk);
      nReset = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic tv; logic [7:0] tb; logic cr; logic [1:0] rs; logic pe; logic rt; logic [7:0] rxd; logic rr; logic er;
      logic [3:0] ctl; logic [7:0] txd; logic trdy; logic rv; logic [7:0] rb; logic es; logic [7:0] dc;
   } vec_t;

   vec_t vt[20];

   function automatic vec_t mk(
      input logic tv, input logic [7:0] tb, input logic cr, input logic [1:0] rs, input logic pe,
      input logic rt, input logic [7:0] rxd, input logic rr, input logic er,
      input logic [3:0] ctl, input logic [7:0] txd, input logic trdy, input logic rv,
      input logic [7:0] rb, input logic es, input logic [7:0] dc);
      vec_t v;
      v.tv = tv; v.tb = tb; v.cr = cr; v.rs = rs; v.pe = pe; v.rt = rt; v.rxd = rxd; v.rr = rr; v.er = er;
      v.ctl = ctl; v.txd = txd; v.trdy = trdy; v.rv = rv; v.rb = rb; v.es = es; v.dc = dc;
      return v;
   endfunction

   // ---------------- reference model (pin-cycle schedule) ----------------
   typedef struct { logic [1:0] dir; logic [7:0] dat; bit sample; } pin_t;
   pin_t sched[$];
   bit         mIdle, mSample, mPend, mHeld, mEs;
   logic [1:0] mDir, mRate;
   logic [7:0] mTxd, mRb;
   int         mDc, mAge;

   task automatic modelReset();
      sched.delete();
      mIdle = 1; mSample = 0; mPend = 0; mHeld = 0; mEs = 0;
      mDir = 2'b00; mRate = 2'b00; mTxd = 8'h00; mRb = 8'h00; mDc = 0; mAge = 0;
   endtask

   // Consumes the inputs of the current cycle and advances to the next cycle.
   task automatic modelStep();
      bit   hs, clr;
      pin_t p;
      hs  = hostIf.tx_valid && mIdle && !mPend;
      clr = 0;
      if (hs && hostIf.tx_byte == 8'h00 && mDc < 255) mDc++;
      if (mIdle) begin
         if (mPend || clear_req) begin
            clr = 1;
            for (int i = 0; i < CLR; i++) sched.push_back('{DIR_CLEAR, 8'h00, 1'b0});
         end else if (hs) begin
            if (hostIf.tx_byte != 8'h00) begin
               sched.push_back('{DIR_TX, hostIf.tx_byte, 1'b0});
               sched.push_back('{DIR_IDLE, 8'h00, 1'b0});
            end
         end else if (rx_poll_en && !mHeld && (mAge >= PI - 1 || rts)) begin
            sched.push_back('{DIR_RX, 8'h00, 1'b0});
            sched.push_back('{DIR_IDLE, 8'h00, 1'b1});
         end
         mRate = rate_sel;
      end
      if (clr) mHeld = 0;
      else if (mSample && rx_data != 8'h00) begin mHeld = 1; mRb = rx_data; end
      else if (mHeld && hostIf.rx_ready) mHeld = 0;
      if (clr) mPend = 0; else if (clear_req) mPend = 1;
      if (clr) mEs = 0; else if (err) mEs = 1;
      if (sched.size() > 0) begin
         p = sched.pop_front();
         mIdle = 0; mDir = p.dir; mTxd = p.dat; mSample = p.sample;
      end else begin
         mIdle = 1; mDir = DIR_IDLE; mTxd = 8'h00; mSample = 0;
      end
      if (mDir == DIR_RX) mAge = 0; else if (mAge < 1000) mAge++;
   endtask

   int  txSeen;
   bit  prevRx;

   initial begin
      idleInputs();

      //      tv  tb     cr rs    pe rt rxd    rr er | ctl      txd   trdy rv rb    es dc
      vt[0]  = mk(1, 8'h41, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0000, 8'h00, 1, 0, 8'h00, 0, 8'd0);
      vt[1]  = mk(0, 8'h00, 0, 2'b10, 0, 0, 8'h00, 0, 0,  4'b0101, 8'h41, 0, 0, 8'h00, 0, 8'd0);
      vt[2]  = mk(0, 8'h00, 0, 2'b10, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 0, 0, 8'h00, 0, 8'd0);
      vt[3]  = mk(1, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 0, 8'h00, 0, 8'd0);
      vt[4]  = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 0, 8'h00, 0, 8'd1);
      vt[5]  = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h5A, 0, 0,  4'b1001, 8'h00, 0, 0, 8'h00, 0, 8'd1);
      vt[6]  = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h5A, 0, 0,  4'b0001, 8'h00, 0, 0, 8'h00, 0, 8'd1);
      vt[7]  = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 1, 8'h5A, 0, 8'd1);
      vt[8]  = mk(0, 8'h00, 0, 2'b01, 1, 1, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 1, 8'h5A, 0, 8'd1);
      vt[9]  = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h00, 1, 0,  4'b0001, 8'h00, 1, 1, 8'h5A, 0, 8'd1);
      vt[10] = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 0, 8'h5A, 0, 8'd1);
      vt[11] = mk(0, 8'h00, 0, 2'b01, 1, 0, 8'h00, 0, 1,  4'b1001, 8'h00, 0, 0, 8'h5A, 0, 8'd1);
      vt[12] = mk(0, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 0, 0, 8'h5A, 1, 8'd1);
      vt[13] = mk(1, 8'hC3, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 0, 8'h5A, 1, 8'd1);
      vt[14] = mk(0, 8'h00, 1, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0101, 8'hC3, 0, 0, 8'h5A, 1, 8'd1);
      vt[15] = mk(0, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 0, 0, 8'h5A, 1, 8'd1);
      vt[16] = mk(1, 8'h77, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 0, 0, 8'h5A, 1, 8'd1);
      vt[17] = mk(1, 8'h77, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b1101, 8'h00, 0, 0, 8'h5A, 0, 8'd1);
      vt[18] = mk(0, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b1101, 8'h00, 0, 0, 8'h5A, 0, 8'd1);
      vt[19] = mk(0, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0,  4'b0001, 8'h00, 1, 0, 8'h5A, 0, 8'd1);

      doReset();
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("tbl%0d_control", i),  32'(control),         32'(vt[i].ctl));
         chk($sformatf("tbl%0d_tx_data", i),  32'(tx_data),         32'(vt[i].txd));
         chk($sformatf("tbl%0d_tx_ready", i), 32'(hostIf.tx_ready), 32'(vt[i].trdy));
         chk($sformatf("tbl%0d_rx_valid", i), 32'(hostIf.rx_valid), 32'(vt[i].rv));
         chk($sformatf("tbl%0d_rx_byte", i),  32'(hostIf.rx_byte),  32'(vt[i].rb));
         chk($sformatf("tbl%0d_err_seen", i), 32'(err_seen),        32'(vt[i].es));
         chk($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt),        32'(vt[i].dc));
         hostIf.tx_valid = vt[i].tv; hostIf.tx_byte = vt[i].tb; clear_req = vt[i].cr; rate_sel = vt[i].rs;
         rx_poll_en = vt[i].pe; rts = vt[i].rt; rx_data = vt[i].rxd; hostIf.rx_ready = vt[i].rr; err = vt[i].er;
         @(negedge clk);
      end

      // 300 zero bytes: counter saturates, no WRITE cycle ever appears.
      doReset();
      hostIf.tx_valid = 1'b1; hostIf.tx_byte = 8'h00;
      txSeen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (control[3:2] == DIR_TX) txSeen++;
      end
      chk("zero_drop_saturate", 32'(drop_cnt), 32'd255);
      chk("zero_drop_no_write", 32'(txSeen), 32'd0);
      hostIf.tx_valid = 1'b0;

      // rts bypasses a nonzero timer; empty poll stays invisible; interval honoured afterwards.
      doReset();
      rx_poll_en = 1'b1; rts = 1'b1;
      @(negedge clk); chk("rts_read_issued", 32'(control[3:2]), 32'(DIR_RX));
      rts = 1'b0;
      @(negedge clk);
      @(negedge clk); chk("empty_poll_rx_valid", 32'(hostIf.rx_valid), 32'd0);
      @(negedge clk); chk("poll_interval_wait", 32'(control[3:2]), 32'(DIR_IDLE));
      @(negedge clk); chk("poll_interval_read", 32'(control[3:2]), 32'(DIR_RX));
      rx_poll_en = 1'b0;

      // Clear discards a held byte and clears err_seen.
      doReset();
      rx_poll_en = 1'b1; rts = 1'b1; err = 1'b1;
      @(negedge clk); chk("clr_seq_read", 32'(control[3:2]), 32'(DIR_RX));
      rx_data = 8'h99; rts = 1'b0; err = 1'b0; rx_poll_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("clr_seq_held", 32'(hostIf.rx_valid), 32'd1);
      chk("clr_seq_byte", 32'(hostIf.rx_byte), 32'h99);
      chk("clr_seq_err_seen", 32'(err_seen), 32'd1);
      clear_req = 1'b1;
      @(negedge clk);
      chk("clr_seq_dir1", 32'(control[3:2]), 32'(DIR_CLEAR));
      chk("clr_seq_discard", 32'(hostIf.rx_valid), 32'd0);
      chk("clr_seq_err_clr", 32'(err_seen), 32'd0);
      clear_req = 1'b0;
      @(negedge clk); chk("clr_seq_dir2", 32'(control[3:2]), 32'(DIR_CLEAR));
      @(negedge clk); chk("clr_seq_done", 32'(control[3:2]), 32'(DIR_IDLE));

      // Simultaneous clear_req and tx_valid in IDLE: CLEAR wins, byte never sent.
      doReset();
      hostIf.tx_valid = 1'b1; hostIf.tx_byte = 8'h5C; clear_req = 1'b1;
      @(negedge clk);
      chk("sim_clear_dir", 32'(control[3:2]), 32'(DIR_CLEAR));
      chk("sim_clear_tx_ready", 32'(hostIf.tx_ready), 32'd0);
      hostIf.tx_valid = 1'b0; clear_req = 1'b0;
      @(negedge clk); chk("sim_clear_dir2", 32'(control[3:2]), 32'(DIR_CLEAR));
      @(negedge clk); chk("sim_clear_idle", 32'(control), 32'b0000);
      @(negedge clk); chk("sim_clear_no_write", 32'(control[3:2]), 32'(DIR_IDLE));

      // Reset pulse in the middle of CLEAR.
      doReset();
      rate_sel = 2'b01; clear_req = 1'b1;
      @(negedge clk); chk("rst_clr_entered", 32'(control), 32'b1101);
      clear_req = 1'b0; rate_sel = 2'b10; rx_poll_en = 1'b1;
      @(posedge clk); #2;
      nReset = 1'b0;
      #1;
      chk("rst_async_control", 32'(control), 32'b0000);
      chk("rst_async_tx_ready", 32'(hostIf.tx_ready), 32'd1);
      @(negedge clk); nReset = 1'b1;
      chk("rst_first_idle", 32'(control), 32'b0000);
      @(negedge clk); chk("rst_rate_applied", 32'(control), 32'b0010);
      @(negedge clk);
      @(negedge clk); chk("rst_timer_not_yet", 32'(control), 32'b0010);
      @(negedge clk); chk("rst_timer_reload", 32'(control), 32'b1010);

      // Random traffic against the schedule model.
      doReset();
      modelReset();
      prevRx = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_control",  32'(control),         32'({mDir, mRate}));
         chk("rnd_tx_data",  32'(tx_data),         32'(mTxd));
         chk("rnd_tx_ready", 32'(hostIf.tx_ready), 32'(mIdle && !mPend));
         chk("rnd_rx_valid", 32'(hostIf.rx_valid), 32'(mHeld));
         chk("rnd_rx_byte",  32'(hostIf.rx_byte),  32'(mRb));
         chk("rnd_err_seen", 32'(err_seen),        32'(mEs));
         chk("rnd_drop_cnt", 32'(drop_cnt),        32'(mDc));
         // Wrapper behaviour: data registered at the end of an RX cycle, held through the next.
         if (control[3:2] == DIR_RX)
            rx_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         else if (!prevRx)
            rx_data = 8'($urandom_range(0, 255));
         prevRx = (control[3:2] == DIR_RX);
         hostIf.tx_valid = ($urandom_range(0, 9) < 4);
         hostIf.tx_byte  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         hostIf.rx_ready = ($urandom_range(0, 9) < 4);
         rate_sel   = 2'($urandom_range(0, 3));
         clear_req  = ($urandom_range(0, 49) == 0);
         rx_poll_en = ($urandom_range(0, 9) < 7);
         rts        = ($urandom_range(0, 9) == 0);
         err        = ($urandom_range(0, 99) == 0);
         modelStep();
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
